// File: rtl/cnt1_pkg.sv
// Shared sizing helpers and the last-word mask generator for cnt1_stream.
package cnt1_pkg;

    // Upper bound on BUS_WIDTH supported by last_word_mask.
    localparam int MAX_BUS_WIDTH = 1024;

    function automatic int sub_vector_no(input int vector_width, input int bus_width);
        return (vector_width + bus_width - 1) / bus_width;
    endfunction

    function automatic int last_bits(input int vector_width, input int bus_width);
        return vector_width - (sub_vector_no(vector_width, bus_width) - 1) * bus_width;
    endfunction

    function automatic int granule_no(input int bus_width, input int granule_width);
        return (bus_width + granule_width - 1) / granule_width;
    endfunction

    function automatic int cnt_width(input int vector_width);
        return $clog2(vector_width + 1);
    endfunction

    function automatic logic [MAX_BUS_WIDTH-1:0] last_word_mask(input int valid_bits);
        logic [MAX_BUS_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BUS_WIDTH; i++) begin
            m[i] = (i < valid_bits);
        end
        return m;
    endfunction

endpackage

// File: rtl/popcnt_granule.sv
// Combinational population count of one GRANULE_WIDTH-bit granule.
module popcnt_granule #(
    parameter int GRANULE_WIDTH = 6
) (
    input  logic [GRANULE_WIDTH-1:0]         bits_i,
    output logic [$clog2(GRANULE_WIDTH+1)-1:0] cnt_o
);

    localparam int CW = $clog2(GRANULE_WIDTH + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < GRANULE_WIDTH; i++) begin
            cnt_o = cnt_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/cnt1_stream.sv
// Streaming vector popcount: masks padding, forwards words, counts per vector in two stages.
// Optional macro CNT1_VEC_ID_EN adds the per-vector sequence ID and the dn_VecId port.
module cnt1_stream
    import cnt1_pkg::*;
#(
    parameter int VECTOR_WIDTH  = 920,
    parameter int BUS_WIDTH     = 128,
    parameter int GRANULE_WIDTH = 6,
    parameter int ID_WIDTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [BUS_WIDTH-1:0]                 up_Vector,
    input  logic                                 up_Valid,
    output logic                                 up_Ready,
    output logic [BUS_WIDTH-1:0]                 dn_SubVector,
    output logic                                 dn_Valid,
    input  logic                                 dn_Ready,
    output logic [cnt_width(VECTOR_WIDTH)-1:0]   dn_Cnt,
    output logic                                 dn_CntNew,
    output logic                                 dn_Last
`ifdef CNT1_VEC_ID_EN
    ,
    output logic [ID_WIDTH-1:0]                  dn_VecId
`endif
);

    localparam int SUB_VECTOR_NO = sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
    localparam int LAST_BITS     = last_bits(VECTOR_WIDTH, BUS_WIDTH);
    localparam int GRANULE_NO    = granule_no(BUS_WIDTH, GRANULE_WIDTH);
    localparam int CNT_WIDTH     = cnt_width(VECTOR_WIDTH);
    localparam int GCNT_WIDTH    = $clog2(GRANULE_WIDTH + 1);
    localparam int PAD_WIDTH     = GRANULE_NO * GRANULE_WIDTH;
    localparam int WIDX_WIDTH    = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
    localparam logic [MAX_BUS_WIDTH-1:0] MASK_FULL = last_word_mask(LAST_BITS);
    localparam logic [BUS_WIDTH-1:0]     LAST_MASK = MASK_FULL[BUS_WIDTH-1:0];

    logic                  advance;
    logic                  accept;
    logic                  up_last;
    logic [WIDX_WIDTH-1:0] widx_q, widx_d;
    logic [BUS_WIDTH-1:0]  masked_word;
    logic [PAD_WIDTH-1:0]  padded_word;
    logic [GCNT_WIDTH-1:0] gcnt [GRANULE_NO];

    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic [BUS_WIDTH-1:0]  s1_data_q;
    logic [GCNT_WIDTH-1:0] s1_gcnt_q [GRANULE_NO];

    logic                  s2_valid_q;
    logic                  s2_last_q;
    logic                  s2_cnt_new_q;
    logic [BUS_WIDTH-1:0]  s2_data_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  acc_q;
    logic [CNT_WIDTH-1:0]  word_cnt;
    logic [CNT_WIDTH-1:0]  acc_sum;

    // Global stall: the whole pipeline moves only when the output slot frees up.
    assign advance  = dn_Ready || !s2_valid_q;
    assign up_Ready = advance;
    assign accept   = up_Valid && advance;
    assign up_last  = (widx_q == WIDX_WIDTH'(SUB_VECTOR_NO - 1));

    assign masked_word = up_last ? (up_Vector & LAST_MASK) : up_Vector;
    assign padded_word = PAD_WIDTH'(masked_word);

    always_comb begin
        widx_d = widx_q;
        if (accept) begin
            widx_d = up_last ? '0 : widx_q + WIDX_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < GRANULE_NO; g++) begin : g_granule
        popcnt_granule #(
            .GRANULE_WIDTH(GRANULE_WIDTH)
        ) u_popcnt_granule (
            .bits_i(padded_word[g*GRANULE_WIDTH +: GRANULE_WIDTH]),
            .cnt_o (gcnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            widx_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            for (int g = 0; g < GRANULE_NO; g++) s1_gcnt_q[g] <= '0;
        end else if (advance) begin
            widx_q     <= widx_d;
            s1_valid_q <= up_Valid;
            if (up_Valid) begin
                s1_last_q <= up_last;
                s1_data_q <= masked_word;
                for (int g = 0; g < GRANULE_NO; g++) s1_gcnt_q[g] <= gcnt[g];
            end
        end
    end

    always_comb begin
        word_cnt = '0;
        for (int g = 0; g < GRANULE_NO; g++) begin
            word_cnt = word_cnt + CNT_WIDTH'(s1_gcnt_q[g]);
        end
        // acc is cleared after every last word, so a first word simply adds to zero.
        acc_sum = acc_q + word_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_cnt_new_q <= 1'b0;
            s2_data_q    <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
        end else if (advance) begin
            s2_valid_q   <= s1_valid_q;
            s2_last_q    <= s1_valid_q && s1_last_q;
            s2_cnt_new_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                s2_data_q <= s1_data_q;
                if (s1_last_q) begin
                    cnt_q <= acc_sum;
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign dn_SubVector = s2_data_q;
    assign dn_Valid     = s2_valid_q;
    assign dn_Cnt       = cnt_q;
    assign dn_CntNew    = s2_cnt_new_q;
    assign dn_Last      = s2_last_q;

`ifdef CNT1_VEC_ID_EN
    logic [ID_WIDTH-1:0] vec_id_q;
    logic [ID_WIDTH-1:0] s1_id_q;
    logic [ID_WIDTH-1:0] s2_id_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vec_id_q <= '0;
            s1_id_q  <= '0;
            s2_id_q  <= '0;
        end else if (advance) begin
            if (up_Valid) begin
                s1_id_q <= vec_id_q;
                if (up_last) vec_id_q <= vec_id_q + ID_WIDTH'(1);
            end
            if (s1_valid_q) s2_id_q <= s1_id_q;
        end
    end

    assign dn_VecId = s2_id_q;
`endif

endmodule
